// File: rtl/ram_sdp.sv
// Simple dual-port coefficient RAM: one write port, one registered read port.
// Read-first on a same-address collision, so a read issued while the loader
// overwrites that address returns the previous contents. Written in the same
// shape as the coefficient ROM so that synthesis maps it onto block RAM.
module ram_sdp #(
    parameter int mem_size   = 9,
    parameter int data_width = 16
) (
    input  logic                        clk,
    input  logic [$clog2(mem_size)-1:0] wr_addr,
    input  logic                        wr_en,
    input  logic [data_width-1:0]       wr_data,
    input  logic [$clog2(mem_size)-1:0] rd_addr,
    input  logic                        rd_ce,
    output logic [data_width-1:0]       q
);

    logic [data_width-1:0] mem_q [mem_size];

    // Write port and registered read port. The nonblocking update of the
    // array keeps a same-cycle read on the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_ce) begin
            q <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Weight stream loader: pops MEM_SIZE coefficients from an ap_fifo stream
// into local RAM on request and serves them through a ROM-like port.
// The defaults match the kernel size and coefficient width used by the
// layer engines (kern_s_10 and coeff_width in the shared headers).
module weight_stream_loader #(
    parameter int MEM_SIZE   = 9,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] input_V_dout,
    input  logic                  input_V_empty_n,
    output logic                  input_V_read,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] weight_address,
    input  logic                  weight_ce,
    output logic [DATA_WIDTH-1:0] weight_q,
    output logic                  weights_ready,
    output logic                  load_done
);

    localparam int RAM_AW = $clog2(MEM_SIZE);
    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(MEM_SIZE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [RAM_AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic                  load_done_q, load_done_d;
    logic                  ready_q, ready_d;
    logic                  rd_ok_q;
    logic                  wr_last;
    logic                  addr_in_range;
    logic [DATA_WIDTH-1:0] ram_q;

    // Addresses past the kernel read as zero instead of aliasing into RAM.
    assign addr_in_range = (32'(weight_address) < 32'(MEM_SIZE));

    // Controller state, write counter, status flags and read-mask flag.
    // rd_ok_q starts at 0 so weight_q reads zero straight out of reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            load_done_q <= 1'b0;
            ready_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            load_done_q <= load_done_d;
            ready_q     <= ready_d;
            if (weight_ce) begin
                rd_ok_q <= addr_in_range;
            end
        end
    end

    // Next-state logic: load_start is honoured only in IDLE and READY, and
    // the counter advances on every popped word.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (input_V_read) begin
                    if (wr_last) begin
                        state_d  = S_READY;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + RAM_AW'(1);
                    end
                end
            end
            S_READY: begin
                if (load_start) begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                wr_cnt_d = '0;
            end
        endcase
        load_done_d = wr_last;
        ready_d     = (state_d == S_READY);
    end

    // Outputs: the stream is popped whenever LOAD sees a word available.
    always_comb begin
        input_V_read = (state_q == S_LOAD) && input_V_empty_n;
        wr_last      = input_V_read && (wr_cnt_q == LAST_ADDR);
    end

    assign weights_ready = ready_q;
    assign load_done     = load_done_q;
    assign weight_q      = rd_ok_q ? ram_q : '0;

    ram_sdp #(
        .mem_size   (MEM_SIZE),
        .data_width (DATA_WIDTH)
    ) u_ram (
        .clk     (ap_clk),
        .wr_addr (wr_cnt_q),
        .wr_en   (input_V_read),
        .wr_data (input_V_dout),
        .rd_addr (weight_address[RAM_AW-1:0]),
        .rd_ce   (weight_ce),
        .q       (ram_q)
    );

endmodule

// File: tb/tb_weight_stream_loader.sv
module tb_weight_stream_loader;

    localparam int MS = 4;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [DW-1:0] input_V_dout = '0;
    logic          input_V_empty_n = 1'b0;
    logic          input_V_read;
    logic          load_start = 1'b0;
    logic [AW-1:0] weight_address = '0;
    logic          weight_ce = 1'b0;
    logic [DW-1:0] weight_q;
    logic          weights_ready;
    logic          load_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo[$];
    logic          gate = 1'b1;
    int            nreads;
    int            ndone;
    int            nready_hi;
    logic [DW-1:0] rdata;

    always #5 ap_clk = ~ap_clk;

    weight_stream_loader #(
        .MEM_SIZE   (MS),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .input_V_dout    (input_V_dout),
        .input_V_empty_n (input_V_empty_n),
        .input_V_read    (input_V_read),
        .load_start      (load_start),
        .weight_address  (weight_address),
        .weight_ce       (weight_ce),
        .weight_q        (weight_q),
        .weights_ready   (weights_ready),
        .load_done       (load_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic upd();
        input_V_empty_n = gate && (fifo.size() > 0);
        input_V_dout    = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    // One clock: pop the FIFO model if the DUT read, then settle 1 ns past the edge.
    task automatic tick();
        logic rd;
        rd = input_V_read;
        @(posedge ap_clk);
        #1;
        if (rd) begin
            void'(fifo.pop_front());
            nreads++;
        end
        if (load_done) ndone++;
        if (weights_ready) nready_hi++;
        upd();
        #1;
    endtask

    task automatic rd_word(input int addr, output logic [DW-1:0] q);
        weight_address = AW'(addr);
        weight_ce      = 1'b1;
        tick();
        weight_ce      = 1'b0;
        q              = weight_q;
    endtask

    task automatic start_load();
        nreads = 0; ndone = 0; nready_hi = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Tick until load_done is seen, bounded by a cycle budget.
    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (ndone == 0 && n < budget) begin
            tick();
            n++;
        end
        if (ndone == 0) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [3:0] gpat [7];
        logic [DW-1:0] exp8;
        int done_at;
        gpat = '{1, 0, 0, 1, 1, 0, 1};

        // Reset state
        #2;
        check("rst_read",  input_V_read, 0);
        check("rst_ready", weights_ready, 0);
        check("rst_done",  load_done, 0);
        check("rst_q",     weight_q, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Back-to-back load
        fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
        gate = 1'b1; upd();
        start_load();
        check("b2b_read_in_load", input_V_read, 1);
        done_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (load_done && done_at < 0) done_at = nreads;
        end
        check("b2b_nreads", nreads, 4);
        check("b2b_ndone", ndone, 1);
        check("b2b_done_after_4th", done_at, 4);
        check("b2b_ready", weights_ready, 1);
        check("b2b_read_idle", input_V_read, 0);
        rd_word(2, rdata); check("b2b_addr2", rdata, 8'h33);
        rd_word(0, rdata); check("b2b_addr0", rdata, 8'h11);

        // Gapped stream (also a reload from READY)
        fifo = '{8'h55, 8'h66, 8'h77, 8'h88};
        start_load();
        check("gap_ready_drop", weights_ready, 0);
        for (int i = 0; i < 7; i++) begin
            gate = gpat[i][0]; upd(); #1;
            check($sformatf("gap_mirror%0d", i), input_V_read, gate);
            check($sformatf("gap_nodone%0d", i), ndone, 0);
            tick();
        end
        gate = 1'b1; upd();
        check("gap_done_after4", ndone, 1);
        check("gap_nreads", nreads, 4);
        for (int a = 0; a < 4; a++) begin
            exp8 = DW'(8'h55 + 8'h11 * a);
            rd_word(a, rdata); check($sformatf("gap_addr%0d", a), rdata, exp8);
        end

        // Ignored request in the 2nd LOAD cycle
        fifo = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_load();
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wait_done("ign", 10);
        repeat (3) tick();
        check("ign_nreads", nreads, 4);
        check("ign_ndone", ndone, 1);
        for (int a = 0; a < 4; a++) begin
            rd_word(a, rdata); check($sformatf("ign_addr%0d", a), rdata, DW'(a + 1));
        end

        // Reload with a 5th word left pending
        fifo = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        start_load();
        wait_done("rel", 10);
        check("rel_ready_low_until_done", nready_hi, 1);
        repeat (3) tick();
        check("rel_fifo_left", fifo.size(), 1);
        check("rel_read_idle", input_V_read, 0);
        check("rel_ndone", ndone, 1);
        rd_word(3, rdata); check("rel_addr3", rdata, 8'hA3);

        // Reset in the middle of a load
        fifo = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        start_load();
        for (int n = 0; n < 10 && nreads < 2; n++) tick();
        check("mid_two_read", nreads, 2);
        #1 ap_rst = 1'b1;
        #1;
        check("mid_rst_read", input_V_read, 0);
        check("mid_rst_ready", weights_ready, 0);
        check("mid_rst_done", load_done, 0);
        ndone = 0;
        repeat (2) tick();
        check("mid_rst_nodone", ndone, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        fifo = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        upd();
        tick();
        check("mid_idle_noread", input_V_read, 0);
        start_load();
        wait_done("mid", 10);
        check("mid_nreads", nreads, 4);
        rd_word(0, rdata); check("mid_addr0", rdata, 8'hC0);
        rd_word(3, rdata); check("mid_addr3", rdata, 8'hC3);

        // Read-port edges
        weight_address = 3'd1; tick();
        check("hold_a1", weight_q, 8'hC3);
        weight_address = 3'd0; tick();
        check("hold_a0", weight_q, 8'hC3);
        rd_word(5, rdata); check("oor_addr5", rdata, 8'h00);
        rd_word(1, rdata); check("after_oor_addr1", rdata, 8'hC1);
        weight_address = 3'd6; tick();
        check("hold_a6", weight_q, 8'hC1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Receiving end of the per-layer weight stream: consumes coefficients from an ap_fifo-style stream and stores them in local RAM.
- Serves the stored coefficients to a convolution engine through a ROM-like port (address/ce/q, one-cycle read latency).
- Sits between the weight-stream source and a layer engine that needs random, repeated access to the kernel.
- Supports reload on command, so a new kernel can be streamed in without resetting the block.

Parameters:
- MEM_SIZE, `kern_s_10: number of coefficients per kernel; must be >= 2.
- DATA_WIDTH, `coeff_width: coefficient width in bits.
- ADDR_WIDTH, $clog2(MEM_SIZE): address width. Derived; do not override.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- input_V_dout  in  DATA_WIDTH  stream data; valid whenever input_V_empty_n=1.
- input_V_empty_n  in  1  stream holds at least one word.
- input_V_read  out  1  pops one word in the current cycle.
- load_start  in  1  single-cycle request to (re)load MEM_SIZE words.
- weight_address  in  ADDR_WIDTH  read address.
- weight_ce  in  1  read enable.
- weight_q  out  DATA_WIDTH  read data, registered.
- weights_ready  out  1  RAM holds a complete kernel.
- load_done  out  1  one-cycle pulse when the last word is written.

Behaviour:
- The clock is ap_clk. Reset is ap_rst: asynchronous and active-high.
- Reset values:
  - state=IDLE, wr_cnt=0.
  - input_V_read=0, weights_ready=0, load_done=0, weight_q=0.
  - RAM contents are undefined.
- States: IDLE, LOAD, READY.
- IDLE:
  - load_start=1 -> LOAD, wr_cnt=0.
  - input_V_read=0.
- LOAD:
  - input_V_read = input_V_empty_n. This is combinational from input_V_empty_n and state; there are no other inputs to it.
  - In every cycle with input_V_read=1: RAM[wr_cnt] <= input_V_dout, and wr_cnt increments.
  - A read cycle with wr_cnt==MEM_SIZE-1 goes to READY, resets wr_cnt to 0, and registers load_done=1 and weights_ready=1 for the next cycle.
  - Stream gaps (empty_n=0) stall the load indefinitely. There is no timeout.
  - load_start in LOAD is ignored.
- READY:
  - weights_ready=1.
  - load_start=1 -> LOAD and wr_cnt=0. weights_ready drops to 0 on the next cycle.
  - input_V_read=0, so extra stream words remain in the FIFO.
- Read port, active in every state:
  - If weight_ce=1, then weight_q <= RAM[weight_address] at the next edge (latency 1).
  - weight_ce=0 holds weight_q.
  - An address >= MEM_SIZE returns 0.
  - Reads while weights_ready=0 return undefined data. The consumer must gate on weights_ready.
- Same-cycle read and write to the same address during LOAD returns the old data (read-first).
- load_done:
  - Asserted for exactly one cycle per completed load.
  - Never asserted for an aborted load.
- Reset mid-LOAD: returns to IDLE immediately, partial data is discarded, and weights_ready=0.
- A reload that is started and then reset leaves weights_ready=0.
- Throughput: one word per cycle. A back-to-back stream completes in MEM_SIZE cycles after entering LOAD.

Decomposition:
- MEM_SIZE/DATA_WIDTH defaults come from the existing shared headers: layers_sizes.vh (`kern_s_*) and my_types.vh (`coeff_width). No new package.
- Localparam state encodings stay inside the module.
- One sub-module: ram_sdp.
  - Simple dual-port RAM with parameters mem_size and data_width.
  - Write port: wr_addr, wr_en, wr_data.
  - Read port: rd_addr, rd_ce, q, registered and read-first.
  - Mirrors the existing rom block so that synthesis infers BRAM.
- The controller FSM, counter and out-of-range masking are in weight_stream_loader.

Test Plan (MEM_SIZE=4, DATA_WIDTH=8):
- Back-to-back load:
  - Stimulus: load_start pulse, then the FIFO presents 0x11,0x22,0x33,0x44 with empty_n=1.
  - Response: input_V_read high for exactly 4 cycles; load_done pulses once in the cycle after the 4th read; weights_ready=1.
  - Then ce with addr 2 -> weight_q=0x33 one cycle later; addr 0 -> 0x11.
- Gapped stream:
  - Stimulus: empty_n toggles 1,0,0,1,1,0,1.
  - Response: input_V_read mirrors empty_n; exactly 4 words are written in order; load_done comes after the 4th accepted word only.
- Ignored request:
  - Stimulus: load_start asserted in the 2nd LOAD cycle.
  - Response: no restart; the load completes with the original words in addresses 0..3.
- Reload:
  - Stimulus: in READY, load_start, then stream 0xA0..0xA3.
  - Response: weights_ready=0 for the next cycle until load_done.
  - Afterwards addr 3 reads 0xA3, and a 5th pending FIFO word is not popped.
- Reset mid-load:
  - Stimulus: assert ap_rst asynchronously after 2 words have been accepted.
  - Response: input_V_read=0 and weights_ready=0 immediately; no load_done.
  - After release, a fresh load_start accepts 4 new words starting at address 0.
- Read-port edges:
  - Stimulus: ce=0 with a changing address.
  - Response: weight_q holds its value.
  - Stimulus: ce=1 with addr 5 (out of range, with ADDR_WIDTH widened in a bench build).
  - Response: weight_q=0.
